// File: rtl/orb_frame_packer.sv
// orb_frame_packer: gathers WPC words per LCB channel from per-channel FIFOs
// on every orbit slot request and writes them into a ping-pong frame RAM.
// A channel that is short of data in a slot is written entirely with FILL.
module orb_frame_packer #(
    parameter int              CH     = 5,
    parameter int              DW     = 12,
    parameter int              AW     = 11,
    parameter int              UW     = 5,
    parameter int              WPC    = 4,
    parameter int              CYCLES = 32,
    parameter logic [DW-1:0]   FILL   = 12'hFFF
) (
    input  logic               clk80MHz,
    input  logic               rst,
    input  logic               rq,
    input  logic [CH*UW-1:0]   usedw,
    input  logic [CH*DW-1:0]   fData,
    output logic [CH-1:0]      rAck,
    output logic [AW-1:0]      wAddr,
    output logic [DW-1:0]      wData,
    output logic               WE,
    output logic               SW,
    output logic               busy,
    output logic [CH-1:0]      miss,
    output logic               ovr
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int IW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int SLW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    localparam logic [CHW-1:0] CH_LAST     = CHW'(CH - 1);
    localparam logic [IW-1:0]  IDX_LAST    = IW'(WPC - 1);
    localparam logic [SLW-1:0] SLOT_LAST   = SLW'(CYCLES - 1);
    localparam logic [UW-1:0]  WPC_LEVEL   = UW'(WPC);
    localparam logic [AW-1:0]  SLOT_STRIDE = AW'(CH * WPC);
    localparam logic [AW-1:0]  CH_STRIDE   = AW'(WPC);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        RD   = 3'd2,
        LAT  = 3'd3,
        WR   = 3'd4,
        NEXT = 3'd5
    } stateT;

    stateT            state, stateNext;
    logic [CHW-1:0]   ch, chNext;
    logic [IW-1:0]    idx, idxNext;
    logic [SLW-1:0]   slot, slotNext;
    logic             avail, availNext;
    logic [CH-1:0]    missNext;
    logic             swNext;
    logic             ovrNext;
    logic [CH-1:0]    rAckNext;
    logic             weNext;
    logic [AW-1:0]    wAddrNext;
    logic [DW-1:0]    wDataNext;

    logic [1:0]       rqSync;
    logic             rqPrev;
    logic             rqEdge;
    logic             availNow;
    logic [AW-1:0]    addrNow;

    logic [UW-1:0]    usedwArr [CH];
    logic [DW-1:0]    fDataArr [CH];

    // Unpack the flat per-channel buses into arrays indexed by channel.
    for (genvar k = 0; k < CH; k++) begin : gUnpack
        assign usedwArr[k] = usedw[k*UW +: UW];
        assign fDataArr[k] = fData[k*DW +: DW];
    end

    // Two-flop synchroniser for rq plus one delay flop for edge detection.
    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            rqSync <= '0;
            rqPrev <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; a
            // blocking chain here would collapse the synchroniser to one stage.
            rqSync <= {rqSync[0], rq};
            rqPrev <= rqSync[1];
        end
    end

    assign rqEdge   = rqSync[1] & ~rqPrev;
    assign availNow = usedwArr[ch] >= WPC_LEVEL;
    assign addrNow  = AW'(slot) * SLOT_STRIDE + AW'(ch) * CH_STRIDE + AW'(idx);

    // Busy covers the edge-detect cycle so the request-to-done window is
    // 3*WPC*CH + 2*CH + 1 clocks; it drops as the FSM returns to IDLE.
    assign busy = (state != IDLE) | rqEdge;

    // State, datapath and registered outputs.
    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ch    <= '0;
            idx   <= '0;
            slot  <= '0;
            avail <= 1'b0;
            miss  <= '0;
            SW    <= 1'b0;
            ovr   <= 1'b0;
            rAck  <= '0;
            WE    <= 1'b0;
            wAddr <= '0;
            wData <= '0;
        end else begin
            state <= stateNext;
            ch    <= chNext;
            idx   <= idxNext;
            slot  <= slotNext;
            avail <= availNext;
            miss  <= missNext;
            SW    <= swNext;
            ovr   <= ovrNext;
            rAck  <= rAckNext;
            WE    <= weNext;
            wAddr <= wAddrNext;
            wData <= wDataNext;
        end
    end

    // Next-state and next-output decode; strobes are registered so rAck is
    // high during RD and WE/wAddr/wData during WR.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        stateNext = state;
        chNext    = ch;
        idxNext   = idx;
        slotNext  = slot;
        availNext = avail;
        missNext  = miss;
        swNext    = SW;
        ovrNext   = ovr | (rqEdge & (state != IDLE));
        rAckNext  = '0;
        weNext    = 1'b0;
        wAddrNext = wAddr;
        wDataNext = wData;

        case (state)
            IDLE: begin
                if (rqEdge) begin
                    stateNext = CHK;
                    chNext    = '0;
                    idxNext   = '0;
                end
            end
            CHK: begin
                // Decide once per channel so a slot never mixes FIFO and FILL.
                availNext      = availNow;
                if (!availNow) begin
                    missNext[ch] = 1'b1;
                end
                rAckNext[ch]   = availNow;
                stateNext      = RD;
            end
            RD: begin
                stateNext = LAT;
            end
            LAT: begin
                // FIFO output is valid now, one clock after the read strobe.
                weNext    = 1'b1;
                wAddrNext = addrNow;
                wDataNext = avail ? fDataArr[ch] : FILL;
                stateNext = WR;
            end
            WR: begin
                if (idx == IDX_LAST) begin
                    stateNext = NEXT;
                end else begin
                    idxNext      = idx + IW'(1);
                    rAckNext[ch] = avail;
                    stateNext    = RD;
                end
            end
            NEXT: begin
                if (ch == CH_LAST) begin
                    stateNext = IDLE;
                    if (slot == SLOT_LAST) begin
                        // Frame complete: hand the bank to the reader.
                        slotNext = '0;
                        swNext   = ~SW;
                        missNext = '0;
                    end else begin
                        slotNext = slot + SLW'(1);
                    end
                end else begin
                    chNext    = ch + CHW'(1);
                    idxNext   = '0;
                    stateNext = CHK;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_orb_frame_packer.sv
// Self-checking bench for orb_frame_packer (CH=2, WPC=4, CYCLES=2, DW=12).
// Queue-style FIFO models feed the DUT; a slot-level reference model predicts
// every frame RAM write, the busy window, rAck counts, SW, miss and ovr.
module tb_orb_frame_packer;

    localparam int          CH     = 2;
    localparam int          DW     = 12;
    localparam int          AW     = 11;
    localparam int          UW     = 5;
    localparam int          WPC    = 4;
    localparam int          CYCLES = 2;
    localparam logic [11:0] FILL   = 12'hFFF;
    localparam int          OBS_N  = 16384;

    logic              clk80MHz;
    logic              rst;
    logic              rq;
    logic [CH*UW-1:0]  usedw;
    logic [CH*DW-1:0]  fData;
    logic [CH-1:0]     rAck;
    logic [AW-1:0]     wAddr;
    logic [DW-1:0]     wData;
    logic              WE;
    logic              SW;
    logic              busy;
    logic [CH-1:0]     miss;
    logic              ovr;

    orb_frame_packer #(
        .CH(CH), .DW(DW), .AW(AW), .UW(UW), .WPC(WPC), .CYCLES(CYCLES), .FILL(FILL)
    ) dut (
        .clk80MHz(clk80MHz),
        .rst(rst),
        .rq(rq),
        .usedw(usedw),
        .fData(fData),
        .rAck(rAck),
        .wAddr(wAddr),
        .wData(wData),
        .WE(WE),
        .SW(SW),
        .busy(busy),
        .miss(miss),
        .ovr(ovr)
    );

    initial begin
        clk80MHz = 1'b0;
        forever #6 clk80MHz = ~clk80MHz;
    end

    // Non-showahead FIFO models: contents written by the stimulus, read side
    // advanced by rAck, data presented the clock after the strobe.
    logic [11:0] fifoMem [CH][256];
    int          wrPtr   [CH] = '{0, 0};
    int          rdPtr   [CH] = '{0, 0};
    logic [11:0] fDataR  [CH] = '{12'h000, 12'h000};

    always @(posedge clk80MHz) begin
        for (int k = 0; k < CH; k++) begin
            if (rAck[k] === 1'b1) begin
                fDataR[k] <= fifoMem[k][rdPtr[k] & 255];
                rdPtr[k]  <= rdPtr[k] + 1;
            end
        end
    end

    assign usedw = {5'(wrPtr[1] - rdPtr[1]), 5'(wrPtr[0] - rdPtr[0])};
    assign fData = {fDataR[1], fDataR[0]};

    // Output monitor, sampled on the falling edge.
    logic [AW-1:0] obsAddr [OBS_N];
    logic [DW-1:0] obsData [OBS_N];
    int            weTotal    = 0;
    int            busyTotal  = 0;
    int            violTotal  = 0;
    int            rackTotal [CH] = '{0, 0};

    always @(negedge clk80MHz) begin
        if (WE === 1'b1) begin
            if (weTotal < OBS_N) begin
                obsAddr[weTotal] <= wAddr;
                obsData[weTotal] <= wData;
            end
            weTotal <= weTotal + 1;
        end
        if (busy === 1'b1) busyTotal <= busyTotal + 1;
        for (int k = 0; k < CH; k++) begin
            if (rAck[k] === 1'b1) rackTotal[k] <= rackTotal[k] + 1;
        end
        if (($countones(rAck) > 1) || ((rAck != '0) && (WE === 1'b1)))
            violTotal <= violTotal + 1;
    end

    int          checks = 0;
    int          errors = 0;
    int          modelSlot = 0;
    logic        modelSw   = 1'b0;
    logic [1:0]  modelMiss = 2'b00;
    logic        modelOvr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushWord(input int c, input logic [11:0] w);
        fifoMem[c][wrPtr[c] & 255] = w;
        wrPtr[c] = wrPtr[c] + 1;
    endtask

    task automatic pulseRq();
        @(posedge clk80MHz);
        #3 rq = 1'b1;
        repeat (3) @(posedge clk80MHz);
        #3 rq = 1'b0;
    endtask

    // One slot: predict from the FIFO contents, request, wait, compare.
    task automatic runSlot(input string tag, input bit midRq);
        logic [AW-1:0] expAddr [8];
        logic [DW-1:0] expData [8];
        int            expRack [CH];
        int            r0 [CH];
        logic [1:0]    shortV;
        int            w0, b0, v0;
        shortV = 2'b00;
        for (int c = 0; c < CH; c++) begin
            int n;
            n = wrPtr[c] - rdPtr[c];
            expRack[c] = (n >= WPC) ? WPC : 0;
            if (n < WPC) shortV[c] = 1'b1;
            for (int i = 0; i < WPC; i++) begin
                expAddr[c*WPC + i] = AW'(modelSlot * CH * WPC + c * WPC + i);
                expData[c*WPC + i] = (n >= WPC) ? fifoMem[c][(rdPtr[c] + i) & 255] : FILL;
            end
            r0[c] = rackTotal[c];
        end
        w0 = weTotal;
        b0 = busyTotal;
        v0 = violTotal;
        pulseRq();
        if (midRq) begin
            repeat (6) @(posedge clk80MHz);
            #3 rq = 1'b1;
            repeat (3) @(posedge clk80MHz);
            #3 rq = 1'b0;
        end
        repeat (40) @(posedge clk80MHz);
        #2;
        check({tag, "_we_count"}, weTotal - w0, CH * WPC);
        for (int j = 0; j < CH * WPC; j++) begin
            check({tag, "_addr"}, 32'(obsAddr[(w0 + j) % OBS_N]), 32'(expAddr[j]));
            check({tag, "_data"}, 32'(obsData[(w0 + j) % OBS_N]), 32'(expData[j]));
        end
        check({tag, "_busy_clocks"}, busyTotal - b0, 3 * WPC * CH + 2 * CH + 1);
        for (int c = 0; c < CH; c++)
            check({tag, "_rack_count"}, rackTotal[c] - r0[c], expRack[c]);
        check({tag, "_strobe_overlap"}, violTotal - v0, 0);
        modelMiss = modelMiss | shortV;
        if (midRq) modelOvr = 1'b1;
        if (modelSlot == CYCLES - 1) begin
            modelSlot = 0;
            modelSw   = ~modelSw;
            modelMiss = 2'b00;
        end else begin
            modelSlot = modelSlot + 1;
        end
        check({tag, "_sw"}, SW, modelSw);
        check({tag, "_miss"}, miss, modelMiss);
        check({tag, "_ovr"}, ovr, modelOvr);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        int w1;
        rst = 1'b0;
        rq  = 1'b0;

        // Reset state.
        #20;
        check("rst_rack", rAck, 0);
        check("rst_we", WE, 0);
        check("rst_waddr", wAddr, 0);
        check("rst_wdata", wData, 0);
        check("rst_sw", SW, 0);
        check("rst_busy", busy, 0);
        check("rst_miss", miss, 0);
        check("rst_ovr", ovr, 0);
        @(posedge clk80MHz);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk80MHz);

        // Both channels full: addresses 0..7 with FIFO data in order.
        for (int i = 0; i < WPC; i++) begin
            pushWord(0, 12'h101 + 12'(i));
            pushWord(1, 12'h201 + 12'(i));
        end
        runSlot("full_slot0", 1'b0);

        // Second slot of the frame: addresses 8..15, SW toggles, miss clear.
        for (int i = 0; i < WPC; i++) begin
            pushWord(0, 12'h141 + 12'(i));
            pushWord(1, 12'h241 + 12'(i));
        end
        runSlot("full_slot1", 1'b0);

        // Channel 1 short by one word: FILL at 4..7, no reads, miss=2'b10.
        for (int i = 0; i < WPC; i++) pushWord(0, 12'h111 + 12'(i));
        for (int i = 0; i < WPC - 1; i++) pushWord(1, 12'h211 + 12'(i));
        runSlot("short_ch1", 1'b0);
        check("short_ch1_fifo_kept", wrPtr[1] - rdPtr[1], 3);

        // Overlapping request mid-slot: ignored but flagged; frame wraps.
        for (int i = 0; i < WPC; i++) pushWord(0, 12'h121 + 12'(i));
        pushWord(1, 12'h214);
        runSlot("overlap", 1'b1);

        // Reset at the 5th write of a slot (channel 1 short, so FILL at 4).
        for (int i = 0; i < WPC; i++) pushWord(0, 12'h301 + 12'(i));
        pulseRq();
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
            @(posedge clk80MHz);
            #2;
            if (WE === 1'b1) n++;
        end
        check("abort_we5_reached", n, 5);
        rst = 1'b0;
        #1;
        check("abort_rack", rAck, 0);
        check("abort_we", WE, 0);
        check("abort_waddr", wAddr, 0);
        check("abort_wdata", wData, 0);
        check("abort_sw", SW, 0);
        check("abort_busy", busy, 0);
        check("abort_miss", miss, 0);
        check("abort_ovr", ovr, 0);
        repeat (2) @(posedge clk80MHz);
        #3 rst = 1'b1;
        modelSlot = 0;
        modelSw   = 1'b0;
        modelMiss = 2'b00;
        modelOvr  = 1'b0;
        w1 = weTotal;
        repeat (12) @(posedge clk80MHz);
        #2;
        check("abort_no_we_after_release", weTotal - w1, 0);
        for (int i = 0; i < WPC; i++) begin
            pushWord(0, 12'h401 + 12'(i));
            pushWord(1, 12'h501 + 12'(i));
        end
        runSlot("after_abort", 1'b0);

        // Randomised slots: random fill levels, contents and overlaps.
        for (int s = 0; s < 1000; s++) begin
            for (int c = 0; c < CH; c++) begin
                int k;
                k = $urandom_range(0, 6);
                while (k > 0 && (wrPtr[c] - rdPtr[c]) < 31) begin
                    pushWord(c, 12'($urandom));
                    k--;
                end
            end
            repeat ($urandom_range(0, 4)) @(posedge clk80MHz);
            runSlot("rand", ($urandom_range(0, 9) == 0));
        end

        check("strobe_overlap_total", violTotal, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/orb_frame_packer.md
ORB_FRAME_PACKER -- requirements
Module: orb_frame_packer

Interface
REQ-001 Parameter CH, default 5: number of LCB channels (1..8).
REQ-002 Parameter DW, default 12: orbit word width.
REQ-003 Parameter AW, default 11: frame RAM address width.
REQ-004 Parameter UW, default 5: FIFO usedw width.
REQ-005 Parameter WPC, default 4: words per channel per request slot.
REQ-006 Parameter CYCLES, default 32: request slots per frame; CYCLES*CH*WPC <= 2^AW.
REQ-007 Parameter FILL, default 12'hFFF: substitute word for missing data.
REQ-008 clk80MHz  in  1  system clock.
REQ-009 rst  in  1  reset, asynchronous, active-low.
REQ-010 rq  in  1  slot request from the orbit timing domain; asynchronous to clk80MHz, high for 2 clk80MHz periods or more.
REQ-011 usedw  in  CH*UW  per-channel FIFO fill level; channel k occupies bits [k*UW +: UW].
REQ-012 fData  in  CH*DW  per-channel FIFO output; non-showahead, valid 1 clock after rAck.
REQ-013 rAck  out  CH  per-channel FIFO read strobe, one-clock pulses.
REQ-014 wAddr  out  AW  frame RAM write address.
REQ-015 wData  out  DW  frame RAM write data.
REQ-016 WE  out  1  frame RAM write enable.
REQ-017 SW  out  1  ping-pong bank select; the bank being filled is the one not read.
REQ-018 busy  out  1  high while a slot is being packed.
REQ-019 miss  out  CH  per-channel sticky flag: channel short of data in the current frame.
REQ-020 ovr  out  1  sticky flag: rq arrived while busy.

Function
REQ-021 rq SHALL pass through a 2-FF synchroniser; a slot SHALL start on the synchronised rising edge only.
REQ-022 FSM states: IDLE, CHK, RD, LAT, WR, NEXT.
REQ-023 IDLE: on rq edge -> CHK; ch=0, idx=0, busy=1.
REQ-024 CHK: latch avail = (usedw[ch] >= WPC); if avail=0, set miss[ch]; -> RD.
REQ-025 RD: if avail, pulse rAck[ch] for 1 clock; -> LAT. If avail=0, no rAck.
REQ-026 LAT: one wait clock for FIFO latency; -> WR.
REQ-027 WR: WE=1 for 1 clock; wData = fData[ch] if avail, else FILL; wAddr = slot*CH*WPC + ch*WPC + idx; -> RD with idx+1, or -> NEXT when idx = WPC-1.
REQ-028 NEXT: if ch < CH-1 -> CHK with ch+1, idx=0; else busy=0, slot+1, -> IDLE.
REQ-029 A channel SHALL never be partially read in a slot: all WPC words come from the FIFO or all are FILL.
REQ-030 Slot packing latency: exactly 3*WPC*CH + 2*CH + 1 clocks from synchronised rq edge to busy falling.
REQ-031 When slot wraps from CYCLES-1 to 0, SW SHALL toggle in the same clock busy falls; miss SHALL clear at that instant.
REQ-032 rq edge while busy: ignored, ovr set; the running slot completes unaffected.
REQ-033 At most one rAck bit and at most one of rAck/WE SHALL be high in any clock.
REQ-034 Address arithmetic at AW bits, no wrap within a frame (guaranteed by REQ-006).

Reset
REQ-035 rst low SHALL force, asynchronously: state IDLE, slot=0, ch=0, idx=0, rAck=0, WE=0, wAddr=0, wData=0, SW=0, busy=0, miss=0, ovr=0, synchroniser=0.
REQ-036 rst assertion mid-slot SHALL abort immediately with no further rAck or WE; after release, the next rq edge starts slot 0.
REQ-037 ovr and miss SHALL clear only by rst (ovr) or frame wrap/rst (miss).

Verification (CH=2, WPC=4, CYCLES=2, DW=12)
REQ-038 Both FIFOs usedw=4 holding 0x101..0x104 and 0x201..0x204, one rq -> WE at addresses 0..7 with those data in order; 8 rAck pulses; busy high 29 clocks; miss=0.
REQ-039 Channel 1 usedw=3 -> addresses 4..7 written 0xFFF; rAck[1] never pulses; miss=2'b10; channel 1 FIFO keeps its 3 words.
REQ-040 Two rq slots -> second slot writes addresses 8..15; SW toggles 0->1 as busy falls; miss clears; third rq writes from address 0 again.
REQ-041 Second rq edge 10 clocks into a slot -> ovr=1; exactly 8 writes; no extra slot started.
REQ-042 rst low at 5th WE of a slot -> all outputs zero at once; after release, no WE until next rq; next rq writes from address 0 with SW=0.
REQ-043 Random usedw/rq over 1000 slots -> checker confirms REQ-029, REQ-033 and the address formula every WE.
